// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_pkg
// Purpose  : Shared vector-unit types and helpers: data width, osize vector
//            type, shift op / shift sequencer state encodings and osize
//            decode functions.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH = 128;

  // Bit i refers to element size 8<<i bits.
  typedef logic [3:0] osize_vector_t;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_READ = 2'b01,
    SEQ_EXEC = 2'b10,
    SEQ_WB   = 2'b11
  } shift_seq_state_e;

  function automatic osize_vector_t osize_to_onehot(input logic [1:0] osize);
    osize_vector_t v;
    case (osize)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

  // Bit i set when osize >= i (thermometer code).
  function automatic osize_vector_t osize_to_greater(input logic [1:0] osize);
    osize_vector_t v;
    case (osize)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0011;
      2'd2:    v = 4'b0111;
      default: v = 4'b1111;
    endcase
    return v;
  endfunction

endpackage : riscv_v_pkg
`default_nettype wire

// File: rtl/riscv_v_shift_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_shift_seq_if
// Purpose  : Bundle of the shift sequencer's issue, VRF read, shifter and
//            VRF write-back signals.
//   master : the sequencer side (drives req_ready, rd_*, sh_* controls and
//            operands, wb_*, done, busy)
//   slave  : the environment side (issue stage, VRF, shifter instance)
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_v_shift_seq_if #(
  parameter int DATA_WIDTH     = 128,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_NREGS_LOG2 = 3
);
  import riscv_v_pkg::*;

  // issue
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [1:0]                req_osize;
  logic [REG_ADDR_WIDTH-1:0] req_vs1;
  logic [REG_ADDR_WIDTH-1:0] req_vs2;
  logic [REG_ADDR_WIDTH-1:0] req_vd;
  logic [MAX_NREGS_LOG2-1:0] req_nregs_m1;
  // VRF read
  logic                      rd_en;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0]     rd_data_a;
  logic [DATA_WIDTH-1:0]     rd_data_b;
  // shifter
  logic                      sh_is_shift;
  logic                      sh_is_left;
  logic                      sh_is_arith;
  osize_vector_t             sh_osize_vector;
  osize_vector_t             sh_is_greater_osize_vector;
  logic [DATA_WIDTH-1:0]     sh_srca;
  logic [DATA_WIDTH-1:0]     sh_srcb;
  logic [DATA_WIDTH-1:0]     sh_result;
  // VRF write-back
  logic                      wb_valid;
  logic                      wb_ready;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;
  // status
  logic                      done;
  logic                      busy;

  modport master (
    input  req_valid, req_op, req_osize, req_vs1, req_vs2, req_vd, req_nregs_m1,
    output req_ready,
    output rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    output sh_is_shift, sh_is_left, sh_is_arith, sh_osize_vector,
    output sh_is_greater_osize_vector, sh_srca, sh_srcb,
    input  sh_result,
    output wb_valid, wb_addr, wb_data,
    input  wb_ready,
    output done, busy
  );

  modport slave (
    output req_valid, req_op, req_osize, req_vs1, req_vs2, req_vd, req_nregs_m1,
    input  req_ready,
    input  rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    input  sh_is_shift, sh_is_left, sh_is_arith, sh_osize_vector,
    input  sh_is_greater_osize_vector, sh_srca, sh_srcb,
    output sh_result,
    input  wb_valid, wb_addr, wb_data,
    output wb_ready,
    input  done, busy
  );

endinterface : riscv_v_shift_seq_if
`default_nettype wire

// File: rtl/riscv_v_shifter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_shifter
// Purpose  : Combinational element-wise vector shifter (SLL/SRL/SRA) for
//            8/16/32/64-bit elements. Shift amount is the low log2(SEW)
//            bits of the matching srca element.
// Ports    : is_shift_i/is_left_i/is_arith_i  operation controls
//            osize_vector_i                   one-hot element size
//            is_greater_osize_vector_i        thermometer element size
//            srca_i                           per-element shift amounts
//            srcb_i                           data to shift
//            result_o                         shifted data (0 if !is_shift)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_v_shifter
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH
) (
  input  logic                  is_shift_i,
  input  logic                  is_left_i,
  input  logic                  is_arith_i,
  input  osize_vector_t         osize_vector_i,
  input  osize_vector_t         is_greater_osize_vector_i,
  input  logic [DATA_WIDTH-1:0] srca_i,
  input  logic [DATA_WIDTH-1:0] srcb_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  function automatic logic [7:0] sh8(input logic [7:0] d, input logic [2:0] s,
                                     input logic left, input logic arith);
    logic [7:0] r;
    if (left)       r = d << s;
    else if (arith) r = $signed(d) >>> s;
    else            r = d >> s;
    return r;
  endfunction

  function automatic logic [15:0] sh16(input logic [15:0] d, input logic [3:0] s,
                                       input logic left, input logic arith);
    logic [15:0] r;
    if (left)       r = d << s;
    else if (arith) r = $signed(d) >>> s;
    else            r = d >> s;
    return r;
  endfunction

  function automatic logic [31:0] sh32(input logic [31:0] d, input logic [4:0] s,
                                       input logic left, input logic arith);
    logic [31:0] r;
    if (left)       r = d << s;
    else if (arith) r = $signed(d) >>> s;
    else            r = d >> s;
    return r;
  endfunction

  function automatic logic [63:0] sh64(input logic [63:0] d, input logic [5:0] s,
                                       input logic left, input logic arith);
    logic [63:0] r;
    if (left)       r = d << s;
    else if (arith) r = $signed(d) >>> s;
    else            r = d >> s;
    return r;
  endfunction

  // The two size encodings must agree; a mismatched pair yields zero rather
  // than an arbitrary mix of element sizes.
  logic ctrl_ok;
  assign ctrl_ok = (is_greater_osize_vector_i ==
                    {osize_vector_i[3], |osize_vector_i[3:2],
                     |osize_vector_i[3:1], |osize_vector_i});

  always_comb begin
    result_o = '0;
    if (is_shift_i && ctrl_ok) begin
      if (osize_vector_i[0]) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++)
          result_o[i*8 +: 8] = sh8(srcb_i[i*8 +: 8], srca_i[i*8 +: 3], is_left_i, is_arith_i);
      end else if (osize_vector_i[1]) begin
        for (int i = 0; i < DATA_WIDTH / 16; i++)
          result_o[i*16 +: 16] = sh16(srcb_i[i*16 +: 16], srca_i[i*16 +: 4], is_left_i, is_arith_i);
      end else if (osize_vector_i[2]) begin
        for (int i = 0; i < DATA_WIDTH / 32; i++)
          result_o[i*32 +: 32] = sh32(srcb_i[i*32 +: 32], srca_i[i*32 +: 5], is_left_i, is_arith_i);
      end else begin
        for (int i = 0; i < DATA_WIDTH / 64; i++)
          result_o[i*64 +: 64] = sh64(srcb_i[i*64 +: 64], srca_i[i*64 +: 6], is_left_i, is_arith_i);
      end
    end
  end

  // Only the low bits of each amount element are meaningful.
  logic unused_srca;
  assign unused_srca = ^srca_i;

endmodule : riscv_v_shifter
`default_nettype wire

// File: rtl/riscv_v_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_shift_seq
// Purpose  : Multi-beat sequencer for one vector-vector shift instruction
//            over a group of 1..8 registers. Per register: read vs1/vs2,
//            drive the external combinational shifter, capture the result,
//            then write it to vd under valid/ready backpressure.
// Ports    : clk, rst (asynchronous, active high)
//            bus (master modport of riscv_v_shift_seq_if):
//              req_*   instruction issue handshake and fields
//              rd_*    VRF read port (data returns one cycle after rd_en)
//              sh_*    shifter controls, operands and result
//              wb_*    VRF write-back handshake
//              done    one-cycle completion pulse, busy = not idle
// Revision : 1.0 - initial release
// ============================================================================
module riscv_v_shift_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH     = RISCV_V_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_NREGS_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  riscv_v_shift_seq_if.master        bus
);

  shift_seq_state_e          state_q, state_d;
  logic [MAX_NREGS_LOG2-1:0] beat_q, beat_d;

  // Latched request
  shift_op_e                 op_q;
  logic                      is_left_q;
  logic                      is_arith_q;
  osize_vector_t             osize_oh_q;
  osize_vector_t             osize_ge_q;
  logic [REG_ADDR_WIDTH-1:0] vs1_q;
  logic [REG_ADDR_WIDTH-1:0] vs2_q;
  logic [REG_ADDR_WIDTH-1:0] vd_q;
  logic [MAX_NREGS_LOG2-1:0] nregs_m1_q;

  // Write-back holding registers
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;

  logic                      accept;
  logic                      capture;
  logic [REG_ADDR_WIDTH-1:0] beat_ext;

  // Register addresses wrap naturally at REG_ADDR_WIDTH bits.
  assign beat_ext = REG_ADDR_WIDTH'(beat_q);

  // --------------------------------------------------------------------------
  // Next state and per-state outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.req_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.sh_is_shift = 1'b0;
    bus.sh_srca   = '0;
    bus.sh_srcb   = '0;
    bus.wb_valid  = 1'b0;
    bus.done      = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        // Held low while rst is asserted so no output is high in reset.
        bus.req_ready = ~rst;
        if (bus.req_valid && !rst) begin
          accept  = 1'b1;
          beat_d  = '0;
          state_d = SEQ_READ;
        end
      end
      SEQ_READ: begin
        bus.rd_en     = 1'b1;
        bus.rd_addr_a = vs1_q + beat_ext;
        bus.rd_addr_b = vs2_q + beat_ext;
        state_d       = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        // VRF data is valid this cycle; pass it straight to the shifter.
        bus.sh_is_shift = (op_q != SHIFT_RSVD);
        bus.sh_srca     = bus.rd_data_a;
        bus.sh_srcb     = bus.rd_data_b;
        capture         = 1'b1;
        state_d         = SEQ_WB;
      end
      SEQ_WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          if (beat_q == nregs_m1_q) begin
            bus.done = 1'b1;
            state_d  = SEQ_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = SEQ_READ;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and write-back holding registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= SHIFT_SLL;
      is_left_q  <= 1'b0;
      is_arith_q <= 1'b0;
      osize_oh_q <= '0;
      osize_ge_q <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      nregs_m1_q <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (accept) begin
        op_q       <= shift_op_e'(bus.req_op);
        is_left_q  <= (bus.req_op == SHIFT_SLL);
        is_arith_q <= (bus.req_op == SHIFT_SRA);
        osize_oh_q <= osize_to_onehot(bus.req_osize);
        osize_ge_q <= osize_to_greater(bus.req_osize);
        vs1_q      <= bus.req_vs1;
        vs2_q      <= bus.req_vs2;
        vd_q       <= bus.req_vd;
        nregs_m1_q <= bus.req_nregs_m1;
      end
      if (capture) begin
        wb_data_q <= bus.sh_result;
        wb_addr_q <= vd_q + beat_ext;
      end
    end
  end

  // Direction/size controls are held from the latched request; only
  // sh_is_shift and the operands are qualified by the EXEC state.
  assign bus.sh_is_left                 = is_left_q;
  assign bus.sh_is_arith                = is_arith_q;
  assign bus.sh_osize_vector            = osize_oh_q;
  assign bus.sh_is_greater_osize_vector = osize_ge_q;
  assign bus.wb_addr                    = wb_addr_q;
  assign bus.wb_data                    = wb_data_q;
  assign bus.busy                       = (state_q != SEQ_IDLE);

endmodule : riscv_v_shift_seq
`default_nettype wire
